// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// owner_t tags which port a load return belongs to.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned STARVE_W       = 8;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear, used to bound how long
// the I/O loader can be denied before it is force-granted.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                at_max
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline (p0) has priority over the I/O loader (p1).
// Build option DMEM_ARB_FAIR_EN adds a starvation counter that force-grants p1.
//
// Return owner (registered, one entry per accepted access)
//   state    | meaning
//   OWN_NONE | no load issued last cycle (idle, store, or reset)
//   OWN_P0   | mem_rdata this cycle belongs to the pipeline
//   OWN_P1   | mem_rdata this cycle belongs to the I/O loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_stall,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..255");
  end

  logic   force_p1;
  logic   p0_win;
  logic   p1_win;
  owner_t owner_q;
  owner_t owner_d;

`ifdef DMEM_ARB_FAIR_EN
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_at_max;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (p1_req & ~p1_gnt),
    .clr    (p1_gnt | ~p1_req),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  assign force_p1 = rst & p1_req & starve_at_max;
`else
  assign force_p1 = 1'b0;
`endif

  // Grants are forced low during reset so every output reads zero.
  assign p0_win = rst & p0_req & ~force_p1;
  assign p1_win = rst & p1_req & (~p0_req | force_p1);

  assign p0_stall = rst & p0_req & ~p0_win;
  assign p1_gnt   = p1_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_win) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_win) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (p0_win && !p0_we) begin
      owner_d = OWN_P0;
    end else if (p1_win && !p1_we) begin
      owner_d = OWN_P1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst drops a load that was in flight when reset arrived.
  assign p0_rdata  = (rst && owner_q == OWN_P0) ? mem_rdata : '0;
  assign p1_rvalid = rst && (owner_q == OWN_P1);
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single-cycle steps plus
// a contention sequence whose expectations depend on DMEM_ARB_FAIR_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_stall;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  dmem_arbiter #(.STARVE_MAX(8), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_stall  (p0_stall),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word memory, word index = addr[9:2], preloaded with 0xA000_00ii.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        q0, w0;
    logic [31:0] a0, d0;
    logic        q1, w1;
    logic [31:0] a1, d1;
    logic [164:0] exp;
  } vec_t;

  function automatic logic [164:0] pk(logic st, logic gn, logic rv, logic en, logic we,
                                      logic [31:0] ma, logic [31:0] md,
                                      logic [31:0] r0, logic [31:0] r1);
    return {st, gn, rv, en, we, ma, md, r0, r1};
  endfunction

  function automatic vec_t v(string n, logic r,
                             logic q0, logic w0, logic [31:0] a0, logic [31:0] d0,
                             logic q1, logic w1, logic [31:0] a1, logic [31:0] d1,
                             logic [164:0] e);
    vec_t t;
    t.name = n; t.rst = r;
    t.q0 = q0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.q1 = q1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.exp = e;
    return t;
  endfunction

  function automatic logic [164:0] outs();
    return {p0_stall, p1_gnt, p1_rvalid, mem_en, mem_we, mem_addr, mem_wdata, p0_rdata, p1_rdata};
  endfunction

  task automatic check(string name, logic [164:0] act, logic [164:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(logic r, logic q0, logic w0, logic [31:0] a0, logic [31:0] d0,
                       logic q1, logic w1, logic [31:0] a1, logic [31:0] d1);
    rst = r;
    p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  vec_t tbl[$];

  initial begin
    logic exp_gnt, exp_rv;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          name            rst q0 w0 a0         d0             q1 w1 a1         d1
    tbl.push_back(v("rst_busy",   0, 1, 0, 32'h100,  0,            1, 0, 32'h2000, 0,
                    pk(0,0,0,0,0, 0, 0, 0, 0)));
    tbl.push_back(v("rst_idle",   0, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 0, 0)));
    tbl.push_back(v("p0_ld_100",  1, 1, 0, 32'h100,  0,            0, 0, 0,        0,
                    pk(0,0,0,1,0, 32'h100, 0, 0, 0)));
    tbl.push_back(v("p0_ld_ret",  1, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 32'hA000_0040, 0)));
    tbl.push_back(v("idle",       1, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 0, 0)));
    tbl.push_back(v("p0_st_40",   1, 1, 1, 32'h40,   32'hDEADBEEF, 0, 0, 0,        0,
                    pk(0,0,0,1,1, 32'h40, 32'hDEADBEEF, 0, 0)));
    tbl.push_back(v("p1_ld_40",   1, 0, 0, 0,        0,            1, 0, 32'h40,   0,
                    pk(0,1,0,1,0, 32'h40, 0, 0, 0)));
    tbl.push_back(v("p1_ld_ret",  1, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,1,0,0, 0, 0, 0, 32'hDEADBEEF)));
    tbl.push_back(v("both_p0win", 1, 1, 0, 32'h104,  0,            1, 0, 32'h2000, 0,
                    pk(0,0,0,1,0, 32'h104, 0, 0, 0)));
    tbl.push_back(v("p1_after",   1, 0, 0, 0,        0,            1, 0, 32'h2000, 0,
                    pk(0,1,0,1,0, 32'h2000, 0, 32'hA000_0041, 0)));
    tbl.push_back(v("alt_p0",     1, 1, 0, 32'h108,  0,            0, 0, 0,        0,
                    pk(0,0,1,1,0, 32'h108, 0, 0, 32'hA000_0000)));
    tbl.push_back(v("alt_p1_st",  1, 0, 0, 0,        0,            1, 1, 32'h44,   32'h12345678,
                    pk(0,1,0,1,1, 32'h44, 32'h12345678, 32'hA000_0042, 0)));
    tbl.push_back(v("p1_ld_2000", 1, 0, 0, 0,        0,            1, 0, 32'h2000, 0,
                    pk(0,1,0,1,0, 32'h2000, 0, 0, 0)));
    tbl.push_back(v("rst_drop",   0, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 0, 0)));
    tbl.push_back(v("post_rst",   1, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 0, 0)));
    tbl.push_back(v("p0_ld_44",   1, 1, 0, 32'h44,   0,            0, 0, 0,        0,
                    pk(0,0,0,1,0, 32'h44, 0, 0, 0)));
    tbl.push_back(v("p0_ld44_ret",1, 0, 0, 0,        0,            0, 0, 0,        0,
                    pk(0,0,0,0,0, 0, 0, 32'h1234_5678, 0)));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].q0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].q1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      check(tbl[i].name, outs(), tbl[i].exp);
    end

    // Continuous contention: p0 loads 0x100, p1 loads 0x2000, after a fresh reset.
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      drive(1'b1, 1, 0, 32'h100, 0, 1, 0, 32'h2000, 0);
      #1;
`ifdef DMEM_ARB_FAIR_EN
      exp_gnt = (c == 9) || (c == 18);
      exp_rv  = (c == 10) || (c == 19);
`else
      exp_gnt = 1'b0;
      exp_rv  = 1'b0;
`endif
      check($sformatf("contend_c%0d", c),
            {123'b0, p1_gnt, p0_stall, p1_rvalid, mem_en, mem_addr, 6'b0},
            {123'b0, exp_gnt, exp_gnt, exp_rv, 1'b1,
             (exp_gnt ? 32'h2000 : 32'h100), 6'b0});
    end

    @(negedge clk);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8: consecutive denied p1 cycles before p1 is force-granted; legal range 1..255.
REQ-002 Parameter ADDR_W, default 32: address width of all ports.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 p0_req  in  1  pipeline exec stage requests memory this cycle.
REQ-007 p0_we  in  1  pipeline request is a store.
REQ-008 p0_addr  in  ADDR_W  pipeline byte address.
REQ-009 p0_wdata  in  32  pipeline store data.
REQ-010 p0_stall  out  1  to hazard unit; pipeline request not accepted this cycle.
REQ-011 p0_rdata  out  32  pipeline load data, valid the cycle after acceptance.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/32  I/O-loader request; same meaning as p0.
REQ-013 p1_gnt  out  1  p1 request accepted this cycle.
REQ-014 p1_rvalid  out  1  p1 load data valid.
REQ-015 p1_rdata  out  32  p1 load data.
REQ-016 mem_en, mem_we  out  1/1  memory access strobe, store strobe.
REQ-017 mem_addr  out  ADDR_W  memory address.
REQ-018 mem_wdata  out  32  memory store data.
REQ-019 mem_rdata  in  32  memory read data, fixed 1-cycle latency after mem_en & !mem_we.

Function
REQ-020 At most one requester is granted per cycle; grant is combinational from the current inputs and counter.
REQ-021 Default policy: p0 wins when both request; p1 is granted only when p0_req is low or a forced grant is active.
REQ-022 mem_en = granted req; mem_we, mem_addr, mem_wdata are muxed from the granted port; when no grant, mem_en=0, mem_we=0, addr/wdata=0.
REQ-023 p0_stall = p0_req & !p0 granted; p1_gnt = p1_req & p1 granted.
REQ-024 Return-owner register (owner_t: OWN_NONE, OWN_P0, OWN_P1) records the port of an accepted load; cleared to OWN_NONE for stores and idle cycles.
REQ-025 Owner OWN_P0: p0_rdata = mem_rdata, p1_rvalid=0. Owner OWN_P1: p1_rvalid=1, p1_rdata = mem_rdata. Otherwise both data outputs are 0.
REQ-026 Starvation counter (8 bit): increments when p1_req & !p1_gnt, saturating at STARVE_MAX; clears to 0 when p1_gnt or !p1_req.
REQ-027 Forced grant: when counter == STARVE_MAX and p1_req, p1 is granted and p0 is stalled even if p0_req; the counter clears the next cycle.
REQ-028 A request withdrawn before grant is dropped without side effects; p1 must hold p1_req/addr/data stable until p1_gnt.
REQ-029 Back-to-back grants to alternating ports are legal; return routing follows the owner register, one access per cycle.

Reset
REQ-030 While rst=0: counter=0, owner=OWN_NONE; mem_en, mem_we, p0_stall, p1_gnt, p1_rvalid = 0; all data outputs 0.
REQ-031 Reset asserted mid-operation discards any in-flight load; no p1_rvalid is produced for it after reset release.
REQ-032 First grant is possible in the first cycle with rst=1.

Configuration
REQ-033 Macro DMEM_ARB_FAIR_EN defined: starvation counter and forced grant (REQ-026, REQ-027) are present.
REQ-034 Macro DMEM_ARB_FAIR_EN undefined: strict p0 priority, no counter logic, STARVE_MAX is unused, p0_stall = 0 whenever rst=1.

Structure
REQ-035 Package dmem_arb_pkg holds owner_t and the STARVE_MAX default constant.
REQ-036 Sub-module starve_counter (saturating counter with clear) is instantiated only under DMEM_ARB_FAIR_EN.

Verification
REQ-037 p0 load addr 0x100 alone -> mem_en=1, mem_addr=0x100, p0_stall=0; the next cycle p0_rdata = mem_rdata.
REQ-038 p0 and p1 request together, counter 0 -> p0 granted, p1_gnt=0, counter increments to 1.
REQ-039 Fair build, STARVE_MAX=8, p0 and p1 requesting continuously -> 8 cycles p0 granted, 9th cycle p1_gnt=1 and p0_stall=1, counter back to 0 the cycle after.
REQ-040 p1 load addr 0x2000 granted, rst=0 the following cycle -> p1_rvalid stays 0; all outputs 0 during reset.
REQ-041 Non-fair build, p0 and p1 requesting for 20 cycles -> p1_gnt never asserts and p0_stall stays 0.
REQ-042 p0 store addr 0x40 data 0xDEADBEEF, then p1 load addr 0x40 -> mem_we=1 with 0xDEADBEEF, then p1_rvalid=1 with p1_rdata=0xDEADBEEF.
